// File: rtl/latch_q_debounce_edge.sv
// Synchronises and debounces an asynchronous latch Q, then emits rise/fall pulses and a saturating edge count.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES+1 edges from first sampling to q_stable; no backpressure (free-running observer).
module latch_q_debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 q_in,
  input  logic                 clr_cnt,
  output logic                 q_stable,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] edge_cnt,
  output logic                 cnt_sat
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_nxt;
  logic [DBW-1:0]         db_cnt, db_cnt_nxt;
  logic                   accept;
  logic [CNT_WIDTH-1:0]   cnt_nxt;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], q_in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_STABLE;
      db_cnt <= '0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    accept     = 1'b0;
    case (state)
      ST_STABLE: begin
        if (s != q_stable) begin
          state_nxt  = ST_CHECK;
          db_cnt_nxt = DBW'(1);
        end
      end
      ST_CHECK: begin
        if (s == q_stable) begin
          // Differing run ended early: treat it as a glitch.
          state_nxt  = ST_STABLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DBW'(DEBOUNCE_CYCLES)) begin
          accept     = 1'b1;
          state_nxt  = ST_STABLE;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + DBW'(1);
        end
      end
      default: begin
        state_nxt  = ST_STABLE;
        db_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_stable   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      if (accept) begin
        q_stable <= s;
      end
      rise_pulse <= accept & s;
      fall_pulse <= accept & ~s;
    end
  end

  // The count follows the registered pulse, so it lands one edge after it.
  always_comb begin
    cnt_nxt = edge_cnt;
    if ((rise_pulse | fall_pulse) && (edge_cnt != {CNT_WIDTH{1'b1}})) begin
      cnt_nxt = edge_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else if (clr_cnt) begin
      edge_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else begin
      edge_cnt <= cnt_nxt;
      cnt_sat  <= cnt_sat | (&cnt_nxt);
    end
  end

endmodule
